// File: rtl/hazard_stall_controller_if.sv
// Decode/execute hazard signals shared between the pipeline and the stall controller.
// master = pipeline side (drives hazard inputs), slave = controller (drives stall controls).
interface hazard_stall_controller_if #(
  parameter int STAT_W = 16
);
  logic [4:0]        RSDecode;
  logic [4:0]        RTDecode;
  logic              UsesRTDecode;
  logic              MulDecode;
  logic              BranchTakenDecode;
  logic [1:0]        MemReadExecute;
  logic              RegWriteExecute;
  logic [4:0]        DestRegExecute;
  logic              StallClear;
  logic              PCWrite;
  logic              IFIDWrite;
  logic              IFIDFlush;
  logic              IDEXBubble;
  logic              IDEXHold;
  logic              MulBusy;
  logic [STAT_W-1:0] StallCount;

  modport master (
    output RSDecode, RTDecode, UsesRTDecode, MulDecode, BranchTakenDecode,
           MemReadExecute, RegWriteExecute, DestRegExecute, StallClear,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXHold, MulBusy, StallCount
  );

  modport slave (
    input  RSDecode, RTDecode, UsesRTDecode, MulDecode, BranchTakenDecode,
           MemReadExecute, RegWriteExecute, DestRegExecute, StallClear,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXHold, MulBusy, StallCount
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Decode->execute hazard sequencer: load-use bubbles, multiply hold, branch flush
// and a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 3,
  parameter int STAT_W      = 16
) (
  input logic                     Clk,
  input logic                     Reset,
  hazard_stall_controller_if.slave hif
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MUL_LATENCY - 1);
  localparam bit               MUL_HOLDS = (MUL_LATENCY > 1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STAT_W-1:0]   stat_q;
  logic                lu;
  logic                stall;

  always_comb begin
    lu = (hif.MemReadExecute != 2'b00) && hif.RegWriteExecute &&
         (hif.DestRegExecute != 5'd0) &&
         ((hif.DestRegExecute == hif.RSDecode) ||
          (hif.UsesRTDecode && (hif.DestRegExecute == hif.RTDecode)));
  end

  assign stall = (state_q == MUL_BUSY) || lu;

  // Priority: multiply hold masks load-use, load-use masks the branch flush.
  always_comb begin
    hif.PCWrite    = 1'b1;
    hif.IFIDWrite  = 1'b1;
    hif.IFIDFlush  = 1'b0;
    hif.IDEXBubble = 1'b0;
    hif.IDEXHold   = 1'b0;
    hif.MulBusy    = 1'b0;
    if (state_q == MUL_BUSY) begin
      hif.PCWrite   = 1'b0;
      hif.IFIDWrite = 1'b0;
      hif.IDEXHold  = 1'b1;
      hif.MulBusy   = 1'b1;
    end else if (lu) begin
      hif.PCWrite    = 1'b0;
      hif.IFIDWrite  = 1'b0;
      hif.IDEXBubble = 1'b1;
    end else if (hif.BranchTakenDecode) begin
      hif.IFIDFlush = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stat_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (!lu && hif.MulDecode && MUL_HOLDS) begin
            state_q <= MUL_BUSY;
            cnt_q   <= HOLD_INIT;
          end
        end
        MUL_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase

      if (hif.StallClear) begin
        stat_q <= '0;
      end else if (stall && (stat_q != '1)) begin
        stat_q <= stat_q + 1'b1;
      end
    end
  end

  assign hif.StallCount = stat_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: two controller instances (4-cycle multiply / 16-bit count and
// single-cycle multiply / 4-bit count) compared against a cycle-level reference model.
module tb_hazard_stall_controller;

  localparam int LAT_M = 4;
  localparam int LAT_S = 1;
  localparam int MAX_M = 65535;
  localparam int MAX_S = 15;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  hazard_stall_controller_if #(.STAT_W(16)) ifm ();
  hazard_stall_controller_if #(.STAT_W(4))  ifs ();

  assign ifs.RSDecode          = ifm.RSDecode;
  assign ifs.RTDecode          = ifm.RTDecode;
  assign ifs.UsesRTDecode      = ifm.UsesRTDecode;
  assign ifs.MulDecode         = ifm.MulDecode;
  assign ifs.BranchTakenDecode = ifm.BranchTakenDecode;
  assign ifs.MemReadExecute    = ifm.MemReadExecute;
  assign ifs.RegWriteExecute   = ifm.RegWriteExecute;
  assign ifs.DestRegExecute    = ifm.DestRegExecute;
  assign ifs.StallClear        = ifm.StallClear;

  hazard_stall_controller #(.MUL_LATENCY(LAT_M), .CNT_W(3), .STAT_W(16)) dut_m (
    .Clk   (Clk),
    .Reset (Reset),
    .hif   (ifm.slave)
  );

  hazard_stall_controller #(.MUL_LATENCY(LAT_S), .CNT_W(3), .STAT_W(4)) dut_s (
    .Clk   (Clk),
    .Reset (Reset),
    .hif   (ifs.slave)
  );

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXHold, MulBusy}
  logic [5:0] obs_m, obs_s;
  assign obs_m = {ifm.PCWrite, ifm.IFIDWrite, ifm.IFIDFlush, ifm.IDEXBubble, ifm.IDEXHold, ifm.MulBusy};
  assign obs_s = {ifs.PCWrite, ifs.IFIDWrite, ifs.IFIDFlush, ifs.IDEXBubble, ifs.IDEXHold, ifs.MulBusy};

  int total  = 0;
  int passed = 0;

  // Reference model: remaining hold cycles and stall count as plain integers.
  int         hold_m = 0, cnt_m = 0, hold_s = 0, cnt_s = 0;
  bit         lu_now;
  logic [5:0] exp_m, exp_s;

  function automatic bit ref_lu();
    bit is_load;
    bit reads_dest;
    is_load    = (ifm.MemReadExecute != 2'b00) && ifm.RegWriteExecute && (ifm.DestRegExecute != 5'd0);
    reads_dest = (ifm.DestRegExecute == ifm.RSDecode) ||
                 (ifm.UsesRTDecode && (ifm.DestRegExecute == ifm.RTDecode));
    return is_load && reads_dest;
  endfunction

  function automatic logic [5:0] ref_out(int hold, bit lu, bit br);
    if (hold > 0) return 6'b000011;
    if (lu)       return 6'b000100;
    return {2'b11, br, 3'b000};
  endfunction

  function automatic int next_cnt(int c, bit stalled, bit clr, int maxv);
    if (clr) return 0;
    if (stalled && c < maxv) return c + 1;
    return c;
  endfunction

  function automatic int next_hold(int h, bit lu, bit mul, int lat);
    if (h > 0) return h - 1;
    if (!lu && mul && lat > 1) return lat - 1;
    return 0;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit usesrt,
                       input bit mul, input bit br, input logic [1:0] mr, input bit rw,
                       input logic [4:0] dest, input bit clr);
    ifm.RSDecode          = rs;
    ifm.RTDecode          = rt;
    ifm.UsesRTDecode      = usesrt;
    ifm.MulDecode         = mul;
    ifm.BranchTakenDecode = br;
    ifm.MemReadExecute    = mr;
    ifm.RegWriteExecute   = rw;
    ifm.DestRegExecute    = dest;
    ifm.StallClear        = clr;
    #1;
    lu_now = ref_lu();
    exp_m  = ref_out(hold_m, lu_now, ifm.BranchTakenDecode);
    exp_s  = ref_out(hold_s, lu_now, ifm.BranchTakenDecode);
  endtask

  task automatic advance();
    if (Reset) begin
      cnt_m  = next_cnt(cnt_m, (hold_m > 0) || lu_now, ifm.StallClear, MAX_M);
      cnt_s  = next_cnt(cnt_s, (hold_s > 0) || lu_now, ifm.StallClear, MAX_S);
      hold_m = next_hold(hold_m, lu_now, ifm.MulDecode, LAT_M);
      hold_s = next_hold(hold_s, lu_now, ifm.MulDecode, LAT_S);
    end else begin
      cnt_m = 0; cnt_s = 0; hold_m = 0; hold_s = 0;
    end
    @(negedge Clk);
  endtask

  task automatic test_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
    total++; if (obs_m !== 6'b110000) $display("FAIL reset_outs_m got=%b exp=%b", obs_m, 6'b110000); else passed++;
    total++; if (ifm.StallCount !== 16'd0) $display("FAIL reset_cnt_m got=%0d exp=0", ifm.StallCount); else passed++;
    total++; if (obs_s !== 6'b110000) $display("FAIL reset_outs_s got=%b exp=%b", obs_s, 6'b110000); else passed++;
    total++; if (ifs.StallCount !== 4'd0) $display("FAIL reset_cnt_s got=%0d exp=0", ifs.StallCount); else passed++;
    advance();
    Reset = 1'b1;
  endtask

  task automatic test_load_use();
    drive(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 5'd8, 1'b0);
    total++; if (obs_m !== 6'b000100) $display("FAIL lu_outs got=%b exp=%b", obs_m, 6'b000100); else passed++;
    total++; if (ifm.StallCount !== 16'd0) $display("FAIL lu_cnt_before got=%0d exp=0", ifm.StallCount); else passed++;
    advance();
    drive(5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 5'd9, 1'b0);
    total++; if (ifm.StallCount !== 16'd1) $display("FAIL lu_cnt_after got=%0d exp=1", ifm.StallCount); else passed++;
    total++; if (obs_m !== exp_m) $display("FAIL lu_clear_outs got=%b exp=%b", obs_m, exp_m); else passed++;
    advance();
  endtask

  task automatic test_no_hazard();
    logic [4:0] rs_v [5] = '{5'd0, 5'd1, 5'd1, 5'd7, 5'd7};
    logic [4:0] rt_v [5] = '{5'd0, 5'd8, 5'd8, 5'd2, 5'd2};
    bit         urt_v[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] mr_v [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    bit         rw_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] ds_v [5] = '{5'd0, 5'd8, 5'd8, 5'd7, 5'd7};
    for (int i = 0; i < 5; i++) begin
      drive(rs_v[i], rt_v[i], urt_v[i], 1'b0, 1'b0, mr_v[i], rw_v[i], ds_v[i], 1'b0);
      total++; if (obs_m !== exp_m) $display("FAIL nohaz_outs[%0d] got=%b exp=%b", i, obs_m, exp_m); else passed++;
      total++; if (ifm.StallCount !== 16'(cnt_m)) $display("FAIL nohaz_cnt[%0d] got=%0d exp=%0d", i, ifm.StallCount, cnt_m); else passed++;
      advance();
    end
  endtask

  task automatic test_mul();
    int c0;
    c0 = cnt_m;
    drive(5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 5'd6, 1'b0);
    total++; if (obs_m !== 6'b110000) $display("FAIL mul_issue_outs got=%b exp=%b", obs_m, 6'b110000); else passed++;
    advance();
    for (int i = 0; i < 3; i++) begin
      // Hazard and branch presented during the hold must be ignored.
      drive(5'd9, 5'd5, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 5'd9, 1'b0);
      total++; if (obs_m !== 6'b000011) $display("FAIL mul_hold_outs[%0d] got=%b exp=%b", i, obs_m, 6'b000011); else passed++;
      total++; if (obs_s !== exp_s) $display("FAIL mul_lat1_outs[%0d] got=%b exp=%b", i, obs_s, exp_s); else passed++;
      advance();
    end
    drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd3, 1'b0);
    total++; if (obs_m !== 6'b110000) $display("FAIL mul_exit_outs got=%b exp=%b", obs_m, 6'b110000); else passed++;
    total++; if (ifm.StallCount !== 16'(c0 + 3)) $display("FAIL mul_cnt got=%0d exp=%0d", ifm.StallCount, c0 + 3); else passed++;
    total++; if (ifs.StallCount !== 4'(cnt_s)) $display("FAIL mul_cnt_s got=%0d exp=%0d", ifs.StallCount, cnt_s); else passed++;
    advance();
  endtask

  task automatic test_branch();
    drive(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 5'd8, 1'b0);
    total++; if (obs_m !== 6'b000100) $display("FAIL br_lu_outs got=%b exp=%b", obs_m, 6'b000100); else passed++;
    advance();
    drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 5'd8, 1'b0);
    total++; if (obs_m !== 6'b111000) $display("FAIL br_flush_outs got=%b exp=%b", obs_m, 6'b111000); else passed++;
    total++; if (obs_s !== 6'b111000) $display("FAIL br_flush_outs_s got=%b exp=%b", obs_s, 6'b111000); else passed++;
    advance();
  endtask

  task automatic test_reset_mid_mul();
    drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
      total++; if (obs_m !== 6'b000011) $display("FAIL rmm_busy[%0d] got=%b exp=%b", i, obs_m, 6'b000011); else passed++;
      if (i == 0) advance();
    end
    #2 Reset = 1'b0;
    #1;
    total++; if (obs_m !== 6'b110000) $display("FAIL rmm_outs got=%b exp=%b", obs_m, 6'b110000); else passed++;
    total++; if (ifm.StallCount !== 16'd0) $display("FAIL rmm_cnt got=%0d exp=0", ifm.StallCount); else passed++;
    total++; if (ifs.StallCount !== 4'd0) $display("FAIL rmm_cnt_s got=%0d exp=0", ifs.StallCount); else passed++;
    hold_m = 0; cnt_m = 0; hold_s = 0; cnt_s = 0;
    @(negedge Clk);
    Reset = 1'b1;
    drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
    total++; if (obs_m !== 6'b110000) $display("FAIL rmm_after got=%b exp=%b", obs_m, 6'b110000); else passed++;
    advance();
  endtask

  task automatic test_saturation();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b1);
    advance();
    for (int i = 0; i < 20; i++) begin
      drive(5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 5'd12, 1'b0);
      total++; if (ifs.StallCount !== 4'(cnt_s)) $display("FAIL sat_cnt_s[%0d] got=%0d exp=%0d", i, ifs.StallCount, cnt_s); else passed++;
      total++; if (ifm.StallCount !== 16'(cnt_m)) $display("FAIL sat_cnt_m[%0d] got=%0d exp=%0d", i, ifm.StallCount, cnt_m); else passed++;
      advance();
    end
    drive(5'd12, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 5'd12, 1'b1);
    total++; if (ifs.StallCount !== 4'hF) $display("FAIL sat_hold got=%0d exp=15", ifs.StallCount); else passed++;
    total++; if (ifm.StallCount !== 16'd20) $display("FAIL sat_m20 got=%0d exp=20", ifm.StallCount); else passed++;
    advance();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
    total++; if (ifs.StallCount !== 4'd0) $display("FAIL sat_clear_s got=%0d exp=0", ifs.StallCount); else passed++;
    total++; if (ifm.StallCount !== 16'd0) $display("FAIL sat_clear_m got=%0d exp=0", ifm.StallCount); else passed++;
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));
      total++; if (obs_m !== exp_m) $display("FAIL rnd_outs_m[%0d] got=%b exp=%b", i, obs_m, exp_m); else passed++;
      total++; if (obs_s !== exp_s) $display("FAIL rnd_outs_s[%0d] got=%b exp=%b", i, obs_s, exp_s); else passed++;
      total++; if (ifm.StallCount !== 16'(cnt_m)) $display("FAIL rnd_cnt_m[%0d] got=%0d exp=%0d", i, ifm.StallCount, cnt_m); else passed++;
      total++; if (ifs.StallCount !== 4'(cnt_s)) $display("FAIL rnd_cnt_s[%0d] got=%0d exp=%0d", i, ifs.StallCount, cnt_s); else passed++;
      total++;
      if ((ifm.IDEXBubble && ifm.IDEXHold) || (ifm.PCWrite !== ifm.IFIDWrite))
        $display("FAIL rnd_invariant[%0d] got bubble=%b hold=%b pcw=%b ifidw=%b exp exclusive/equal",
                 i, ifm.IDEXBubble, ifm.IDEXHold, ifm.PCWrite, ifm.IFIDWrite);
      else passed++;
      advance();
    end
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mul();
    test_branch();
    test_reset_mid_mul();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
